// File: rtl/intc_nto1_sel_pipe.sv
// Pipelined N-to-1 interrupt selector: a registered binary max-priority tree
// feeding a registered output stage with mask compare and winner-change pulse.
module intc_nto1_sel_pipe #(
  parameter int NUM_IN = 8,
  parameter int VEC_DW = 8,
  parameter int PRI_DW = 4,
  parameter int DW     = VEC_DW + PRI_DW,
  parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [NUM_IN-1:0]    req_vld_i,
  input  logic [NUM_IN*DW-1:0] req_dat_i,
  input  logic [PRI_DW-1:0]    imask_i,
  output logic                 sel_vld_o,
  output logic [DW-1:0]        sel_dat_o,
  output logic [IDX_W-1:0]     sel_idx_o,
  output logic                 irq_o,
  output logic                 chg_o
);

  localparam int LV = $clog2(NUM_IN);
  localparam int NP = 1 << LV;

  logic             leaf_vld_s [NP];
  logic [DW-1:0]    leaf_dat_s [NP];
  logic [IDX_W-1:0] leaf_idx_s [NP];

  logic             root_vld_s;
  logic [DW-1:0]    root_dat_s;
  logic [IDX_W-1:0] root_idx_s;

  logic             sel_vld_r;
  logic [DW-1:0]    sel_dat_r;
  logic [IDX_W-1:0] sel_idx_r;
  logic             irq_r;
  logic             chg_r;

  logic [DW-1:0]    out_dat_s;
  logic [IDX_W-1:0] out_idx_s;
  logic             irq_s;
  logic             chg_s;

  // Leaves beyond NUM_IN are padding that can never be valid.
  for (genvar k = 0; k < NP; k++) begin : g_leaf
    if (k < NUM_IN) begin : g_real
      assign leaf_vld_s[k] = req_vld_i[k];
      assign leaf_dat_s[k] = req_dat_i[k*DW +: DW];
    end else begin : g_pad
      assign leaf_vld_s[k] = 1'b0;
      assign leaf_dat_s[k] = {DW{1'b0}};
    end
    assign leaf_idx_s[k] = IDX_W'(k);
  end

  if (NP > 1) begin : g_tree
    // Heap layout: node i has children 2i+1 (lower indices) and 2i+2;
    // leaf k sits at heap position NN+k, so the tree is LV levels deep.
    localparam int NN = NP - 1;

    logic             node_vld_r [NN];
    logic [DW-1:0]    node_dat_r [NN];
    logic [IDX_W-1:0] node_idx_r [NN];
    logic             nxt_vld_s  [NN];
    logic [DW-1:0]    nxt_dat_s  [NN];
    logic [IDX_W-1:0] nxt_idx_s  [NN];

    for (genvar i = 0; i < NN; i++) begin : g_node
      localparam int CA = 2*i + 1;
      localparam int CB = 2*i + 2;
      logic             va_s, vb_s, a_win_s;
      logic [DW-1:0]    da_s, db_s;
      logic [IDX_W-1:0] ia_s, ib_s;

      if (CA >= NN) begin : g_leaf_kids
        assign va_s = leaf_vld_s[CA-NN];
        assign da_s = leaf_dat_s[CA-NN];
        assign ia_s = leaf_idx_s[CA-NN];
        assign vb_s = leaf_vld_s[CB-NN];
        assign db_s = leaf_dat_s[CB-NN];
        assign ib_s = leaf_idx_s[CB-NN];
      end else begin : g_node_kids
        assign va_s = node_vld_r[CA];
        assign da_s = node_dat_r[CA];
        assign ia_s = node_idx_r[CA];
        assign vb_s = node_vld_r[CB];
        assign db_s = node_dat_r[CB];
        assign ib_s = node_idx_r[CB];
      end

      // Strict compare lets the higher-index child win ties.
      assign a_win_s      = va_s && (!vb_s || (da_s[DW-1:VEC_DW] > db_s[DW-1:VEC_DW]));
      assign nxt_vld_s[i] = a_win_s ? va_s : vb_s;
      assign nxt_dat_s[i] = a_win_s ? da_s : db_s;
      assign nxt_idx_s[i] = a_win_s ? ia_s : ib_s;
    end

    // Tree node registers, one level per clock when enabled.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < NN; i++) begin
          node_vld_r[i] <= 1'b0;
          node_dat_r[i] <= {DW{1'b0}};
          node_idx_r[i] <= {IDX_W{1'b0}};
        end
      end else if (en_i) begin
        for (int i = 0; i < NN; i++) begin
          node_vld_r[i] <= nxt_vld_s[i];
          node_dat_r[i] <= nxt_dat_s[i];
          node_idx_r[i] <= nxt_idx_s[i];
        end
      end
    end

    assign root_vld_s = node_vld_r[0];
    assign root_dat_s = node_dat_r[0];
    assign root_idx_s = node_idx_r[0];
  end else begin : g_single
    assign root_vld_s = leaf_vld_s[0];
    assign root_dat_s = leaf_dat_s[0];
    assign root_idx_s = leaf_idx_s[0];
  end

  // Output-stage next values: zeroed payload when invalid, mask compare, change detect.
  always_comb begin
    out_dat_s = {DW{1'b0}};
    out_idx_s = {IDX_W{1'b0}};
    irq_s     = 1'b0;
    if (root_vld_s) begin
      out_dat_s = root_dat_s;
      out_idx_s = root_idx_s;
      irq_s     = (root_dat_s[DW-1:VEC_DW] > imask_i);
    end else begin
      out_dat_s = {DW{1'b0}};
      out_idx_s = {IDX_W{1'b0}};
      irq_s     = 1'b0;
    end
    chg_s = ({root_vld_s, out_idx_s, out_dat_s} != {sel_vld_r, sel_idx_r, sel_dat_r});
  end

  // Output registers; chg only ever pulses on an advancing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_vld_r <= 1'b0;
      sel_dat_r <= {DW{1'b0}};
      sel_idx_r <= {IDX_W{1'b0}};
      irq_r     <= 1'b0;
      chg_r     <= 1'b0;
    end else if (en_i) begin
      sel_vld_r <= root_vld_s;
      sel_dat_r <= out_dat_s;
      sel_idx_r <= out_idx_s;
      irq_r     <= irq_s;
      chg_r     <= chg_s;
    end else begin
      chg_r     <= 1'b0;
    end
  end

  assign sel_vld_o = sel_vld_r;
  assign sel_dat_o = sel_dat_r;
  assign sel_idx_o = sel_idx_r;
  assign irq_o     = irq_r;
  assign chg_o     = chg_r;

endmodule

// File: tb/tb_intc_nto1_sel_pipe.sv
// Bench for intc_nto1_sel_pipe: NUM_IN=8, 5 and 1 builds share one stimulus and
// are compared against a max-priority reference delayed by each build's latency.
module tb_intc_nto1_sel_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  vld = 8'h00;
  logic [95:0] dat = 96'h0;
  logic [3:0]  imask = 4'h0;

  logic        s8_vld, s8_irq, s8_chg;
  logic [11:0] s8_dat;
  logic [2:0]  s8_idx;
  logic        s5_vld, s5_irq, s5_chg;
  logic [11:0] s5_dat;
  logic [2:0]  s5_idx;
  logic        s1_vld, s1_irq, s1_chg;
  logic [11:0] s1_dat;
  logic [0:0]  s1_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  intc_nto1_sel_pipe #(.NUM_IN(8)) dut8 (
    .clk(clk), .rst(rst), .en_i(en), .req_vld_i(vld), .req_dat_i(dat),
    .imask_i(imask), .sel_vld_o(s8_vld), .sel_dat_o(s8_dat), .sel_idx_o(s8_idx),
    .irq_o(s8_irq), .chg_o(s8_chg));

  intc_nto1_sel_pipe #(.NUM_IN(5)) dut5 (
    .clk(clk), .rst(rst), .en_i(en), .req_vld_i(vld[4:0]), .req_dat_i(dat[59:0]),
    .imask_i(imask), .sel_vld_o(s5_vld), .sel_dat_o(s5_dat), .sel_idx_o(s5_idx),
    .irq_o(s5_irq), .chg_o(s5_chg));

  intc_nto1_sel_pipe #(.NUM_IN(1)) dut1 (
    .clk(clk), .rst(rst), .en_i(en), .req_vld_i(vld[0:0]), .req_dat_i(dat[11:0]),
    .imask_i(imask), .sel_vld_o(s1_vld), .sel_dat_o(s1_dat), .sel_idx_o(s1_idx),
    .irq_o(s1_irq), .chg_o(s1_chg));

  typedef struct packed {
    logic        vld;
    logic [11:0] dat;
    logic [4:0]  idx;
  } res_t;

  // Reference state per build: results still in flight, plus current outputs.
  res_t dl [3][3];
  res_t mo [3];
  logic mirq [3];
  logic mchg [3];

  function automatic int nin(int d);
    return (d == 0) ? 8 : ((d == 1) ? 5 : 1);
  endfunction

  function automatic int lvl(int d);
    return (d == 2) ? 0 : 3;
  endfunction

  // Highest priority valid entry among the first n; ties go to the highest index.
  function automatic res_t ref_win(int n);
    res_t r;
    int   best;
    r    = '0;
    best = -1;
    for (int k = 0; k < n; k++) begin
      if (vld[k] && (best < 0 || dat[k*12+8 +: 4] >= dat[best*12+8 +: 4])) best = k;
    end
    if (best >= 0) begin
      r.vld = 1'b1;
      r.dat = dat[best*12 +: 12];
      r.idx = 5'(best);
    end
    return r;
  endfunction

  task automatic model_edge();
    res_t w, root;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        for (int j = 0; j < 3; j++) dl[d][j] = '0;
        mo[d]   = '0;
        mirq[d] = 1'b0;
        mchg[d] = 1'b0;
      end else if (en) begin
        w = ref_win(nin(d));
        if (lvl(d) == 0) begin
          root = w;
        end else begin
          root = dl[d][lvl(d)-1];
          for (int j = lvl(d) - 1; j > 0; j--) dl[d][j] = dl[d][j-1];
          dl[d][0] = w;
        end
        mchg[d] = (root != mo[d]);
        mirq[d] = root.vld && (root.dat[11:8] > imask);
        mo[d]   = root;
      end else begin
        mchg[d] = 1'b0;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_n8", {12'h0, s8_vld, s8_irq, s8_chg, 2'b00, s8_idx, s8_dat},
        {12'h0, mo[0].vld, mirq[0], mchg[0], mo[0].idx, mo[0].dat});
    chk("model_n5", {12'h0, s5_vld, s5_irq, s5_chg, 2'b00, s5_idx, s5_dat},
        {12'h0, mo[1].vld, mirq[1], mchg[1], mo[1].idx, mo[1].dat});
    chk("model_n1", {12'h0, s1_vld, s1_irq, s1_chg, 4'b0000, s1_idx, s1_dat},
        {12'h0, mo[2].vld, mirq[2], mchg[2], mo[2].idx, mo[2].dat});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_entry(int k, logic v, logic [3:0] p, logic [7:0] vec);
    vld[k]          = v;
    dat[k*12 +: 12] = {p, vec};
  endtask

  initial begin
    // Reset state
    rst = 1'b1; en = 1'b0;
    tick();
    chk("reset_outs", {s8_vld, s8_irq, s8_chg, s8_idx, s8_dat}, 32'h0);
    rst = 1'b0; en = 1'b1;

    // Basic select, 4-cycle latency
    set_entry(0, 1'b1, 4'd3, 8'h10);
    set_entry(2, 1'b1, 4'd9, 8'h12);
    set_entry(5, 1'b1, 4'd6, 8'h15);
    imask = 4'd4;
    for (int i = 0; i < 3; i++) tick();
    chk("basic_early_vld", {31'h0, s8_vld}, 32'h0);
    tick();
    chk("basic_idx", {29'h0, s8_idx}, 32'd2);
    chk("basic_dat", {20'h0, s8_dat}, 32'h912);
    chk("basic_irq_chg", {30'h0, s8_irq, s8_chg}, 32'h3);
    tick();
    chk("basic_chg_once", {31'h0, s8_chg}, 32'h0);

    // Tie-break toward the higher index, then fall back after vld[6] drops
    vld = 8'h00;
    set_entry(1, 1'b1, 4'd7, 8'h21);
    set_entry(6, 1'b1, 4'd7, 8'h26);
    for (int i = 0; i < 4; i++) tick();
    chk("tie_idx", {29'h0, s8_idx}, 32'd6);
    vld[6] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("tie_hold_idx", {29'h0, s8_idx}, 32'd6);
    tick();
    chk("tie_drop_idx", {29'h0, s8_idx}, 32'd1);
    chk("tie_drop_chg", {31'h0, s8_chg}, 32'h1);

    // Mask threshold sweep on a single pri=5 entry
    vld = 8'h00;
    set_entry(3, 1'b1, 4'd5, 8'h33);
    for (int i = 0; i < 5; i++) tick();
    imask = 4'd4; tick();
    chk("mask4", {29'h0, s8_vld, s8_irq, s8_chg}, 32'h6);
    imask = 4'd5; tick();
    chk("mask5", {29'h0, s8_vld, s8_irq, s8_chg}, 32'h4);
    imask = 4'd6; tick();
    chk("mask6", {29'h0, s8_vld, s8_irq, s8_chg}, 32'h4);

    // Enable hold mid-stream with a new winner every cycle
    imask = 4'd0;
    for (int i = 0; i < 14; i++) begin
      vld = 8'h00;
      set_entry(i % 8, 1'b1, 4'(i + 1), 8'(8'h40 + i));
      en = !(i >= 5 && i <= 7);
      tick();
      if (!en) chk("hold_chg", {31'h0, s8_chg}, 32'h0);
    end
    en = 1'b1;

    // Reset mid-flight: outputs clear, then reappear L=4 advancing cycles later
    vld = 8'h00;
    set_entry(4, 1'b1, 4'd12, 8'h44);
    tick(); tick();
    rst = 1'b1; tick();
    chk("rst_mid_outs", {s8_vld, s8_irq, s8_chg, s8_idx, s8_dat}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_rel_early", {30'h0, s8_vld, s8_chg}, 32'h0);
    tick();
    chk("rst_rel_back", {30'h0, s8_vld, s8_chg}, 32'h3);
    chk("rst_rel_dat", {20'h0, s8_dat}, 32'hC44);

    // Random traffic on all three builds
    for (int c = 0; c < 10000; c++) begin
      vld   = 8'($urandom);
      for (int k = 0; k < 8; k++) dat[k*12 +: 12] = 12'($urandom);
      imask = 4'($urandom);
      en    = ($urandom_range(0, 9) != 0);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
      if (s5_vld) chk("n5_pad_never_wins", {31'h0, (s5_idx < 3'd5)}, 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
